demux_1_4_pipe: RTL and testbench

Registered 1-to-4 stream demultiplexer: steers each `W`-bit word from a single valid/ready input to one of four valid/ready outputs chosen by a 2-bit select. It is the counterpart of the team's 4:1 mux. It is built as a tree of three registered 1:2 stages, with `sel[1]` used in the first stage and `sel[0]` in the second. It is the fan-out element in the lab's streaming datapaths.

---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_1_2_pipe.sv | 99 +++++++++
 rtl/demux_1_4_pipe.sv | 123 ++++++++++++
 tb/tb_demux_1_4_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1:4 registered stream demultiplexer.
//   sel_t  : destination index 0..3
//   N_OUT  : number of output ports
//   CNT_W  : width of the optional per-output transfer counters
//   W_DEF  : default data width
package demux_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned W_DEF = 4;

  typedef logic [1:0] sel_t;

  // Splits a destination index into its first-stage and second-stage route bits.
  function automatic logic route_hi(input sel_t s);
    return s[1];
  endfunction

  function automatic logic route_lo(input sel_t s);
    return s[0];
  endfunction

endpackage

// File: rtl/demux_1_2_pipe.sv
// Registered 1:2 valid/ready steering stage with a single-entry holding slot.
//   clk, rst_n          : clock, asynchronous active-low reset
//   up_valid/up_ready   : upstream handshake (up_ready is combinational)
//   up_data             : upstream word
//   up_sel              : route bit, 0 -> port 0, 1 -> port 1
//   up_tag              : optional side tag carried with the word (TW = 0: none)
//   dn_valid[1:0]       : per-port valid, only the routed port is set
//   dn_ready[1:0]       : per-port ready
//   dn_data0/dn_data1   : per-port data; each holds its last delivered word
//   dn_tag              : tag of the held word (0 when TW = 0)
module demux_1_2_pipe
  import demux_pkg::*;
#(
  parameter  int unsigned W   = W_DEF,
  parameter  int unsigned TW  = 0,
  localparam int unsigned TWE = (TW == 0) ? 1 : TW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           up_valid,
  output logic           up_ready,
  input  logic [W-1:0]   up_data,
  input  logic           up_sel,
  input  logic [TWE-1:0] up_tag,
  output logic [1:0]     dn_valid,
  input  logic [1:0]     dn_ready,
  output logic [W-1:0]   dn_data0,
  output logic [W-1:0]   dn_data1,
  output logic [TWE-1:0] dn_tag
);

  // One-hot valid per port; the slot is full when either bit is set and
  // the destination is the upper bit.
  logic [1:0]   valid_q;
  logic [W-1:0] d0_q;
  logic [W-1:0] d1_q;
  logic         full;
  logic         dest;
  logic         up_xfer;
  logic         dn_xfer;

  assign full     = |valid_q;
  assign dest     = valid_q[1];

  // Ready when empty, or when the held word leaves this same cycle.
  assign up_ready = !full || dn_ready[dest];
  assign up_xfer  = up_valid && up_ready;
  assign dn_xfer  = full && dn_ready[dest];

  assign dn_valid = valid_q;
  assign dn_data0 = d0_q;
  assign dn_data1 = d1_q;

  // Slot occupancy: a load always wins over a drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 2'b00;
    end else if (up_xfer) begin
      valid_q <= up_sel ? 2'b10 : 2'b01;
    end else if (dn_xfer) begin
      valid_q <= 2'b00;
    end
  end

  // Per-port data registers: only the routed port is written, so the
  // other port keeps presenting the last word it delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q <= '0;
      d1_q <= '0;
    end else if (up_xfer) begin
      if (up_sel) begin
        d1_q <= up_data;
      end else begin
        d0_q <= up_data;
      end
    end
  end

  // Optional tag register travelling with the word.
  if (TW > 0) begin : g_tag
    logic [TW-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_q <= '0;
      end else if (up_xfer) begin
        tag_q <= up_tag;
      end
    end

    assign dn_tag = tag_q;
  end else begin : g_no_tag
    logic unused_tag;
    assign unused_tag = ^up_tag;
    assign dn_tag     = '0;
  end

endmodule

// File: rtl/demux_1_4_pipe.sv
// Registered 1:4 valid/ready stream demultiplexer built as a two-level tree
// of demux_1_2_pipe stages: stage A routes on in_sel[1] and carries in_sel[0]
// as a tag; stage B0 (outputs 0/1) and B1 (outputs 2/3) route on that tag.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready/in_*  : input stream; in_ready has no path from in_valid
//   out_valid[3:0]          : per-output valid
//   out_ready[3:0]          : per-output ready
//   out_d0..out_d3          : output words, holding last value when idle
//   out_cnt0..out_cnt3      : per-output transfer counters (8-bit, wrapping),
//                             present only when DEMUX_1_4_CNT_EN is defined
module demux_1_4_pipe
  import demux_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
`ifdef DEMUX_1_4_CNT_EN
  output logic [CNT_W-1:0] out_cnt0,
  output logic [CNT_W-1:0] out_cnt1,
  output logic [CNT_W-1:0] out_cnt2,
  output logic [CNT_W-1:0] out_cnt3,
`endif
  output logic [W-1:0]     out_d0,
  output logic [W-1:0]     out_d1,
  output logic [W-1:0]     out_d2,
  output logic [W-1:0]     out_d3
);

  sel_t         sel;
  logic [1:0]   a_valid;
  logic [1:0]   a_ready;
  logic [W-1:0] a_d0;
  logic [W-1:0] a_d1;
  logic         a_tag;
  logic [1:0]   b0_valid;
  logic [1:0]   b1_valid;
  logic         unused_b0_tag;
  logic         unused_b1_tag;

  assign sel = sel_t'(in_sel);

  // Stage A: upper select bit picks the B branch, lower bit rides as tag.
  demux_1_2_pipe #(.W(W), .TW(1)) u_stage_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (in_valid),
    .up_ready (in_ready),
    .up_data  (in_data),
    .up_sel   (route_hi(sel)),
    .up_tag   (route_lo(sel)),
    .dn_valid (a_valid),
    .dn_ready (a_ready),
    .dn_data0 (a_d0),
    .dn_data1 (a_d1),
    .dn_tag   (a_tag)
  );

  // Stage B0: outputs 0 and 1.
  demux_1_2_pipe #(.W(W), .TW(0)) u_stage_b0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (a_valid[0]),
    .up_ready (a_ready[0]),
    .up_data  (a_d0),
    .up_sel   (a_tag),
    .up_tag   (1'b0),
    .dn_valid (b0_valid),
    .dn_ready (out_ready[1:0]),
    .dn_data0 (out_d0),
    .dn_data1 (out_d1),
    .dn_tag   (unused_b0_tag)
  );

  // Stage B1: outputs 2 and 3.
  demux_1_2_pipe #(.W(W), .TW(0)) u_stage_b1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (a_valid[1]),
    .up_ready (a_ready[1]),
    .up_data  (a_d1),
    .up_sel   (a_tag),
    .up_tag   (1'b0),
    .dn_valid (b1_valid),
    .dn_ready (out_ready[3:2]),
    .dn_data0 (out_d2),
    .dn_data1 (out_d3),
    .dn_tag   (unused_b1_tag)
  );

  assign out_valid = {b1_valid, b0_valid};

`ifdef DEMUX_1_4_CNT_EN
  // Per-output transfer counters; natural 8-bit wrap.
  logic [CNT_W-1:0] cnt_q [N_OUT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_OUT); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N_OUT); k++) begin
        if (out_valid[k] && out_ready[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign out_cnt0 = cnt_q[0];
  assign out_cnt1 = cnt_q[1];
  assign out_cnt2 = cnt_q[2];
  assign out_cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux_1_4_pipe.sv
// Self-checking bench for demux_1_4_pipe: directed steps plus random traffic,
// checked against per-output expected-word queues.
module tb_demux_1_4_pipe;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_d0, out_d1, out_d2, out_d3;
`ifdef DEMUX_1_4_CNT_EN
  logic [7:0]   out_cnt0, out_cnt1, out_cnt2, out_cnt3;
`endif

  always #5 clk = ~clk;

  demux_1_4_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX_1_4_CNT_EN
    .out_cnt0  (out_cnt0),
    .out_cnt1  (out_cnt1),
    .out_cnt2  (out_cnt2),
    .out_cnt3  (out_cnt3),
`endif
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_d3    (out_d3)
  );

  logic [W-1:0] od [4];
  assign od[0] = out_d0;
  assign od[1] = out_d1;
  assign od[2] = out_d2;
  assign od[3] = out_d3;
`ifdef DEMUX_1_4_CNT_EN
  logic [7:0] oc [4];
  assign oc[0] = out_cnt0;
  assign oc[1] = out_cnt1;
  assign oc[2] = out_cnt2;
  assign oc[3] = out_cnt3;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: words still owed to each output, the last word each
  // output delivered, stall history and transfer counts.
  typedef logic [W-1:0] word_q_t [$];
  word_q_t      exp_q [4];
  logic [W-1:0] last_d [4];
  logic [W-1:0] prev_d [4];
  logic [3:0]   prev_stall;
  int           xfer_cnt [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: everything is sampled on the falling edge, so a valid&&ready
  // seen here is the transfer that happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[k].delete();
        last_d[k]   = '0;
        prev_d[k]   = '0;
        xfer_cnt[k] = 0;
      end
      prev_stall = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!out_valid[k])
          chk($sformatf("idle_d%0d", k), 32'(od[k]), 32'(last_d[k]));
        else if (prev_stall[k])
          chk($sformatf("stable_d%0d", k), 32'(od[k]), 32'(prev_d[k]));
`ifdef DEMUX_1_4_CNT_EN
        chk($sformatf("cnt%0d", k), 32'(oc[k]), 32'(xfer_cnt[k] % 256));
`endif
        if (out_valid[k] && out_ready[k]) begin
          chk($sformatf("owed_d%0d", k), 32'(exp_q[k].size() > 0), 32'(1));
          if (exp_q[k].size() > 0) begin
            chk($sformatf("data_d%0d", k), 32'(od[k]), 32'(exp_q[k].pop_front()));
            last_d[k] = od[k];
            xfer_cnt[k]++;
          end
        end
        prev_stall[k] = out_valid[k] && !out_ready[k];
        prev_d[k]     = od[k];
      end
      if (in_valid && in_ready)
        exp_q[in_sel].push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_d0"}, 32'(out_d0), 32'(0));
    chk({tag, "_d1"}, 32'(out_d1), 32'(0));
    chk({tag, "_d2"}, 32'(out_d2), 32'(0));
    chk({tag, "_d3"}, 32'(out_d3), 32'(0));
`ifdef DEMUX_1_4_CNT_EN
    chk({tag, "_cnt"}, 32'({out_cnt3, out_cnt2, out_cnt1, out_cnt0}), 32'(0));
`endif
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 4'hf;
    for (int i = 0; i < 20; i++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0)
        break;
      step();
    end
    step();
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_left%0d", tag, k), 32'(exp_q[k].size()), 32'(0));
  endtask

  // Present one word with everything ready and time its appearance.
  task automatic latency_word(input logic [W-1:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_early", 32'(out_valid), 32'(0));
    step();
    @(negedge clk);
    chk($sformatf("lat_valid_s%0d", s), 32'(out_valid), 32'(4'(1) << s));
    chk($sformatf("lat_data_s%0d", s), 32'(od[s]), 32'(d));
    step();
  endtask

  logic [W-1:0] xw;

  initial begin
    xw        = 'x;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = 4'hf;
    #12;
    check_reset("rst0");
    step();
    rst_n = 1'b1;

    // Single-word latency per select.
    latency_word(W'(4'ha), 2'd0);
    latency_word(W'(4'hb), 2'd1);
    latency_word(W'(4'hc), 2'd2);
    latency_word(W'(4'hd), 2'd3);

    // Full-rate stream, cycling select.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i % 4);
      in_data  = W'($urandom);
      @(negedge clk);
      chk("rate_in_ready", 32'(in_ready), 32'(1));
      if (i >= 2)
        chk("rate_one_out", 32'($countones(out_valid)), 32'(1));
      step();
    end
    drain("rate");

    // Backpressure on output 2, with a word for output 0 queued behind.
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = W'(3);
    step();
    in_data = W'(10);
    step();
    in_sel  = 2'd0;
    in_data = W'(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_valid2", 32'(out_valid), 32'(4'b0100));
      chk("bp_hold_d2", 32'(out_d2), 32'(3));
      step();
    end
    out_ready = 4'hf;
    @(negedge clk);
    chk("bp_rel_ready", 32'(in_ready), 32'(1));
    chk("bp_rel_d2a", 32'(out_d2), 32'(3));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_rel_valid", 32'(out_valid), 32'(4'b0100));
    chk("bp_rel_d2b", 32'(out_d2), 32'(10));
    step();
    @(negedge clk);
    chk("bp_hol_valid", 32'(out_valid), 32'(4'b0001));
    chk("bp_hol_d0", 32'(out_d0), 32'(5));
    drain("bp");

    // X passthrough with intact neighbours.
    in_valid = 1'b1;
    in_sel = 2'd0; in_data = W'(7);  step();
    in_sel = 2'd3; in_data = xw;     step();
    in_sel = 2'd1; in_data = W'(10); step();
    drain("xp");
    chk("xp_d3", 32'(out_d3), 32'(xw));
    chk("xp_d0", 32'(out_d0), 32'(7));
    chk("xp_d1", 32'(out_d1), 32'(10));

    // Random traffic and random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = W'($urandom);
      out_ready = 4'($urandom);
      step();
    end
    drain("rnd");

    // Reset asserted mid-stream discards in-flight words.
    out_ready = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'($urandom_range(0, 3));
      in_data  = W'($urandom);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    in_valid = 1'b0;
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 4'hf;
    @(negedge clk);
    check_reset("rst_rel");
    step();

`ifdef DEMUX_1_4_CNT_EN
    // 257 transfers on output 1 wrap its counter to 1.
    in_valid = 1'b1;
    in_sel   = 2'd1;
    for (int i = 0; i < 257; i++) begin
      in_data = W'($urandom);
      step();
    end
    drain("cnt");
    chk("cnt_final1", 32'(out_cnt1), 32'(1));
    chk("cnt_final0", 32'(out_cnt0), 32'(0));
    chk("cnt_final2", 32'(out_cnt2), 32'(0));
    chk("cnt_final3", 32'(out_cnt3), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
